// File: rtl/decoy_rx.sv
// Decoy-flag receiver: packs per-slot decoy bits into WORD_W-bit words aligned to PPS epochs.
// Optional DECOY_RX_CNT_EN adds a per-epoch count of decoy_in=1 slots on output decoy_cnt.
module decoy_rx #(
  parameter int WORD_W = 32
) (
  input  logic              clk240,
  input  logic              rst_240,
  input  logic              pps_i,
  input  logic              pps_trigger,
  input  logic              slot_en,
  input  logic              decoy_in,
  output logic [WORD_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              overflow,
`ifdef DECOY_RX_CNT_EN
  output logic [31:0]       decoy_cnt,
`endif
  output logic [1:0]        state_o
);

  localparam int CNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_PPS = 2'b01,
    ST_RUN      = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_pps_s1;
  logic               r_pps_s2;
  logic               r_pps_d;
  logic               r_pps_edge;
  logic [1:0]         r_warm;
  logic               r_pps_low_seen;

  logic [CNT_W-1:0]   r_slot_cnt;
  logic [WORD_W-1:0]  r_shift;
  logic               r_first;

  logic               w_pps_edge;
  logic               w_run;
  logic               w_boundary;
  logic               w_capture;
  logic               w_complete;
  logic               w_xfer;
  logic               w_arm;
  logic               w_first;
  logic [CNT_W-1:0]   w_base_cnt;
  logic [WORD_W-1:0]  w_word;

  // PPS synchronizer and edge detector. An edge is only accepted once the
  // synchronized level has been seen low after reset, so a PPS that is
  // already high when reset releases never produces a spurious boundary.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk240) begin
    if (!rst_240) begin
      r_pps_s1       <= 1'b0;
      r_pps_s2       <= 1'b0;
      r_pps_d        <= 1'b0;
      r_pps_edge     <= 1'b0;
      r_warm         <= 2'b00;
      r_pps_low_seen <= 1'b0;
    end else begin
      r_pps_s1       <= pps_i;
      r_pps_s2       <= r_pps_s1;
      r_pps_d        <= r_pps_s2;
      r_pps_edge     <= r_pps_s2 & ~r_pps_d & r_pps_low_seen;
      r_warm         <= {r_warm[0], 1'b1};
      r_pps_low_seen <= r_pps_low_seen | (r_warm[1] & ~r_pps_s2);
    end
  end

  assign w_pps_edge = r_pps_edge;

  always_ff @(posedge clk240) begin
    if (!rst_240) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (pps_trigger) w_state_next = ST_WAIT_PPS;
      ST_WAIT_PPS: if (w_pps_edge)  w_state_next = ST_RUN;
      ST_RUN:      w_state_next = ST_RUN;
      default:     w_state_next = ST_IDLE;
    endcase
    if (!pps_trigger) w_state_next = ST_IDLE;
  end

  assign state_o    = r_state;
  assign w_run      = (r_state == ST_RUN) && pps_trigger;
  assign w_boundary = w_pps_edge && pps_trigger &&
                      ((r_state == ST_RUN) || (r_state == ST_WAIT_PPS));
  assign w_capture  = slot_en && w_run;
  assign w_xfer     = m_tvalid && m_tready;
  assign w_arm      = (r_state == ST_IDLE) && pps_trigger;

  // The epoch boundary is applied before the slot write, so a slot landing
  // on the boundary cycle becomes bit 0 of a fresh word.
  always_comb begin
    w_base_cnt = w_boundary ? '0 : r_slot_cnt;
    w_word     = w_boundary ? '0 : r_shift;
    w_first    = w_boundary | r_first;
    if (w_capture) w_word[w_base_cnt] = decoy_in;
  end

  assign w_complete = w_capture && (w_base_cnt == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk240) begin
    if (!rst_240) begin
      r_slot_cnt <= '0;
      r_shift    <= '0;
      r_first    <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tuser    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (!w_run) begin
        r_slot_cnt <= '0;
        r_shift    <= '0;
      end else if (w_capture) begin
        r_slot_cnt <= w_base_cnt + CNT_W'(1);
        r_shift    <= w_complete ? '0 : w_word;
      end else begin
        r_slot_cnt <= w_base_cnt;
        r_shift    <= w_word;
      end

      if (!pps_trigger)    r_first <= 1'b0;
      else if (w_complete) r_first <= 1'b0;
      else                 r_first <= w_first;

      // A held word blocks a new one unless it transfers on this same edge.
      if (w_complete && (!m_tvalid || w_xfer)) begin
        m_tdata  <= w_word;
        m_tuser  <= w_first;
        m_tvalid <= 1'b1;
      end else if (w_xfer) begin
        m_tvalid <= 1'b0;
      end

      if (w_arm)
        overflow <= 1'b0;
      else if (w_complete && m_tvalid && !w_xfer)
        overflow <= 1'b1;
    end
  end

`ifdef DECOY_RX_CNT_EN
  logic [31:0] r_acc;
  logic        w_cnt_inc;

  assign w_cnt_inc = w_capture && decoy_in;

  always_ff @(posedge clk240) begin
    if (!rst_240) begin
      r_acc     <= '0;
      decoy_cnt <= '0;
    end else if (w_pps_edge) begin
      decoy_cnt <= r_acc;
      r_acc     <= 32'(w_cnt_inc);
    end else if (w_cnt_inc) begin
      r_acc     <= r_acc + 32'd1;
    end
  end
`endif

endmodule

// File: doc/decoy_rx.md
DECOY_RX -- requirements
Module: decoy_rx

Interface
REQ-001 Parameter: WORD_W, 32, slots packed per output word; legal values 8, 16, 32.
REQ-002 clk240  input  1  sole clock, 240 MHz.
REQ-003 rst_240  input  1  synchronous, active-low reset, sampled on clk240 rising edge.
REQ-004 pps_i  input  1  asynchronous pulse-per-second; rising edge marks an epoch boundary.
REQ-005 pps_trigger  input  1  arm level; 1 = capture enabled, 0 = return to idle.
REQ-006 slot_en  input  1  one-cycle strobe per qubit slot.
REQ-007 decoy_in  input  1  received decoy flag, valid when slot_en=1.
REQ-008 m_tdata  output  WORD_W  packed decoy word.
REQ-009 m_tvalid  output  1  word valid.
REQ-010 m_tready  input  1  downstream ready.
REQ-011 m_tuser  output  1  1 = first word after a pps edge.
REQ-012 overflow  output  1  sticky: a completed word was dropped.
REQ-013 state_o  output  2  current FSM state (00 IDLE, 01 WAIT_PPS, 10 RUN).

Function
REQ-014 pps_i SHALL pass a 2-flop synchronizer and a registered edge detector; internal pps_edge pulses one cycle, 3 clk240 cycles after pps_i is first sampled high.
REQ-015 FSM: IDLE -> WAIT_PPS when pps_trigger=1; WAIT_PPS -> RUN on pps_edge; any state -> IDLE when pps_trigger=0.
REQ-016 In IDLE and WAIT_PPS, slot_en SHALL be ignored and the bit counter held at 0.
REQ-017 In RUN, each slot_en SHALL write decoy_in to bit position slot_cnt of the shift word (bit 0 first), then increment slot_cnt modulo WORD_W.
REQ-018 On the slot_en writing bit WORD_W-1, the completed word SHALL load m_tdata and m_tvalid SHALL assert on the next cycle (1-cycle latency).
REQ-019 m_tdata and m_tuser SHALL remain stable while m_tvalid=1 and m_tready=0; transfer occurs when both are 1 on a clock edge.
REQ-020 If a word completes while m_tvalid=1 and m_tready=0 in the same cycle, the new word SHALL be dropped, m_tdata retained, overflow set to 1.
REQ-021 If a word completes in the same cycle that the held word transfers, the new word SHALL load with no overflow.
REQ-022 pps_edge in RUN SHALL discard the partial word and reset slot_cnt to 0; the next completed word carries m_tuser=1, later words m_tuser=0.
REQ-023 pps_edge and slot_en in the same cycle: the boundary SHALL apply first; decoy_in becomes bit 0 of the new word.
REQ-024 The WAIT_PPS -> RUN transition SHALL also mark the first word m_tuser=1.
REQ-025 pps_trigger falling SHALL discard the partial word; a pending valid word SHALL remain until transferred.
REQ-026 overflow SHALL clear only on reset or on the IDLE -> WAIT_PPS transition.

Reset
REQ-027 While rst_240=0 at a clock edge: state IDLE, slot_cnt 0, shift word 0, m_tdata 0, m_tvalid 0, m_tuser 0, overflow 0, synchronizer flops 0.
REQ-028 Reset asserted mid-word or with m_tvalid=1 SHALL discard all data; no edge is inferred from pps_i already high when reset releases.

Configuration
REQ-029 Macro DECOY_RX_CNT_EN defined: add output decoy_cnt (32 bits, reset 0), counting decoy_in=1 slots in RUN; on each pps_edge the count SHALL latch into decoy_cnt and the internal counter restart (same-cycle slot counted in the new epoch).
REQ-030 DECOY_RX_CNT_EN undefined: no decoy_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-031 Reset held 5 cycles with random inputs -> all outputs 0, state_o=00.
REQ-032 Arm, pps edge, 32 slot_en every 6 cycles with decoy_in 1,0,1,0... and m_tready=1 -> m_tdata=0x55555555, m_tuser=1; second such word has m_tuser=0.
REQ-033 m_tready=0 across two full words (first all ones, second all zeros) -> overflow=1, m_tdata=0xFFFFFFFF retained.
REQ-034 pps edge after 10 slots, then 32 slots of 1 -> partial discarded, single word 0xFFFFFFFF with m_tuser=1.
REQ-035 slot_en with decoy_in=1 in the same cycle as pps_edge, then 31 slots of 0 -> m_tdata=0x00000001.
REQ-036 With DECOY_RX_CNT_EN: 100 slots containing 37 ones between two pps edges -> decoy_cnt=37 the cycle after the second pps_edge.
